// File: rtl/pbus_pkg.sv
// Shared FSM encoding and default address map for the peripheral bus interconnect.
package pbus_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam int DEF_N_SLV   = 5;
    localparam int DEF_AW      = 12;
    localparam int DEF_DW      = 8;
    localparam int DEF_TIMEOUT = 15;

    // Slave 0 sits in the LSBs; with this map slave 3 shadows slave 4 since lower indices win.
    localparam logic [DEF_N_SLV*DEF_AW-1:0] DEF_SLV_BASE =
        {12'hC00, 12'h800, 12'h700, 12'h6F0, 12'h600};
    localparam logic [DEF_N_SLV*DEF_AW-1:0] DEF_SLV_MASK =
        {12'hC00, 12'h800, 12'hF00, 12'hFF0, 12'hFFC};
    localparam logic [DEF_N_SLV-1:0] DEF_SLV_AUTOACK = 5'b00011;

endpackage

// File: rtl/pbus_addr_dec.sv
// Combinational address decoder: one-hot slave hit (lowest index wins) plus miss flag.
module pbus_addr_dec
    import pbus_pkg::*;
#(
    parameter int                  N_SLV    = DEF_N_SLV,
    parameter int                  AW       = DEF_AW,
    parameter logic [N_SLV*AW-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [N_SLV*AW-1:0] SLV_MASK = DEF_SLV_MASK
) (
    input  logic [AW-1:0]    addr,
    output logic [N_SLV-1:0] hit,
    output logic             miss
);

    logic found_s;

    // Priority decode: the first matching window claims the access.
    always_comb begin
        hit     = {N_SLV{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < N_SLV; i++) begin
            if (!found_s && ((addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW])) begin
                hit[i]  = 1'b1;
                found_s = 1'b1;
            end else begin
                hit[i] = 1'b0;
            end
        end
        miss = ~found_s;
    end

endmodule

// File: rtl/pbus_ic.sv
// Single-master peripheral bus interconnect: decodes, strobes one slave, waits for
// ACK (or auto-acks), times out, and returns a registered ACK/ERR response.
module pbus_ic
    import pbus_pkg::*;
#(
    parameter int                  N_SLV       = DEF_N_SLV,
    parameter int                  AW          = DEF_AW,
    parameter int                  DW          = DEF_DW,
    parameter logic [N_SLV*AW-1:0] SLV_BASE    = DEF_SLV_BASE,
    parameter logic [N_SLV*AW-1:0] SLV_MASK    = DEF_SLV_MASK,
    parameter logic [N_SLV-1:0]    SLV_AUTOACK = DEF_SLV_AUTOACK,
    parameter int                  TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         WB_ADRi,
    input  logic [DW-1:0]         WB_DATi,
    input  logic                  WB_WEi,
    input  logic                  WB_CYCi,
    input  logic                  WB_STBi,
    output logic [DW-1:0]         WB_DATo,
    output logic                  WB_ACKo,
    output logic                  WB_ERRo,
    output logic [AW-1:0]         S_ADRo,
    output logic [DW-1:0]         S_DATo,
    output logic                  S_WEo,
    output logic                  S_CYCo,
    output logic [N_SLV-1:0]      S_STBo,
    input  logic [N_SLV*DW-1:0]   S_DATi,
    input  logic [N_SLV-1:0]      S_ACKi,
    output logic [AW-1:0]         ERR_ADDR,
    output logic                  ERR_IRQ
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]       state_r;
    logic [7:0]       wait_cnt_r;
    logic [AW-1:0]    adr_r;
    logic [DW-1:0]    dat_r;
    logic             we_r;
    logic             cyc_r;
    logic [N_SLV-1:0] stb_r;
    logic             ack_r;
    logic             err_r;
    logic             irq_r;
    logic [DW-1:0]    rdat_r;
    logic [AW-1:0]    err_addr_r;

    logic [N_SLV-1:0] hit_s;
    logic             miss_s;
    logic             sel_ack_s;
    logic             sel_auto_s;
    logic [DW-1:0]    sel_dat_s;

    pbus_addr_dec #(
        .N_SLV    (N_SLV),
        .AW       (AW),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .addr (WB_ADRi),
        .hit  (hit_s),
        .miss (miss_s)
    );

    // The live strobe register doubles as the slave select for ACK and read data.
    assign sel_ack_s  = |(S_ACKi & stb_r);
    assign sel_auto_s = |(SLV_AUTOACK & stb_r);

    // Read-data mux for the selected slave.
    always_comb begin
        sel_dat_s = {DW{1'b0}};
        for (int i = 0; i < N_SLV; i++) begin
            sel_dat_s = sel_dat_s | (S_DATi[i*DW +: DW] & {DW{stb_r[i]}});
        end
    end

    // Transaction FSM with registered bus and response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 8'd0;
            adr_r      <= {AW{1'b0}};
            dat_r      <= {DW{1'b0}};
            we_r       <= 1'b0;
            cyc_r      <= 1'b0;
            stb_r      <= {N_SLV{1'b0}};
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
            irq_r      <= 1'b0;
            rdat_r     <= {DW{1'b0}};
            err_addr_r <= {AW{1'b0}};
        end else begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            irq_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (WB_CYCi && WB_STBi) begin
                        adr_r      <= WB_ADRi;
                        dat_r      <= WB_DATi;
                        we_r       <= WB_WEi;
                        wait_cnt_r <= 8'd0;
                        if (miss_s) begin
                            state_r    <= ST_RESP;
                            err_r      <= 1'b1;
                            irq_r      <= 1'b1;
                            err_addr_r <= WB_ADRi;
                            if (!WB_WEi) rdat_r <= {DW{1'b1}};
                        end else begin
                            state_r <= ST_ACCESS;
                            stb_r   <= hit_s;
                            cyc_r   <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!WB_CYCi) begin
                        state_r <= ST_IDLE;
                        stb_r   <= {N_SLV{1'b0}};
                        cyc_r   <= 1'b0;
                    end else if (sel_auto_s || sel_ack_s) begin
                        state_r <= ST_RESP;
                        stb_r   <= {N_SLV{1'b0}};
                        cyc_r   <= 1'b0;
                        ack_r   <= 1'b1;
                        rdat_r  <= sel_dat_s;
                    end else if (wait_cnt_r == TO_LAST) begin
                        state_r    <= ST_RESP;
                        stb_r      <= {N_SLV{1'b0}};
                        cyc_r      <= 1'b0;
                        err_r      <= 1'b1;
                        irq_r      <= 1'b1;
                        err_addr_r <= adr_r;
                        if (!we_r) rdat_r <= {DW{1'b1}};
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    stb_r   <= {N_SLV{1'b0}};
                    cyc_r   <= 1'b0;
                end
            endcase
        end
    end

    assign WB_DATo  = rdat_r;
    assign WB_ACKo  = ack_r;
    assign WB_ERRo  = err_r;
    assign S_ADRo   = adr_r;
    assign S_DATo   = dat_r;
    assign S_WEo    = we_r;
    assign S_CYCo   = cyc_r;
    assign S_STBo   = stb_r;
    assign ERR_ADDR = err_addr_r;
    assign ERR_IRQ  = irq_r;

endmodule

// File: tb/tb_pbus_ic.sv
// Randomized bench for pbus_ic: a transaction-level model predicts every output cycle by cycle.
module tb_pbus_ic;

    localparam int N_SLV   = 5;
    localparam int AW      = 12;
    localparam int DW      = 8;
    localparam int TIMEOUT = 15;

    localparam logic [AW-1:0] MAP_BASE [N_SLV] = '{12'h600, 12'h6F0, 12'h700, 12'h800, 12'hC00};
    localparam logic [AW-1:0] MAP_MASK [N_SLV] = '{12'hFFC, 12'hFF0, 12'hF00, 12'h800, 12'hC00};
    localparam bit            AUTO     [N_SLV] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0]       WB_ADRi = '0;
    logic [DW-1:0]       WB_DATi = '0;
    logic                WB_WEi  = 1'b0;
    logic                WB_CYCi = 1'b0;
    logic                WB_STBi = 1'b0;
    logic [DW-1:0]       WB_DATo;
    logic                WB_ACKo, WB_ERRo;
    logic [AW-1:0]       S_ADRo;
    logic [DW-1:0]       S_DATo;
    logic                S_WEo, S_CYCo;
    logic [N_SLV-1:0]    S_STBo;
    logic [N_SLV*DW-1:0] S_DATi = '0;
    logic [N_SLV-1:0]    S_ACKi = '0;
    logic [AW-1:0]       ERR_ADDR;
    logic                ERR_IRQ;

    pbus_ic dut (
        .clk(clk), .rst(rst),
        .WB_ADRi(WB_ADRi), .WB_DATi(WB_DATi), .WB_WEi(WB_WEi), .WB_CYCi(WB_CYCi), .WB_STBi(WB_STBi),
        .WB_DATo(WB_DATo), .WB_ACKo(WB_ACKo), .WB_ERRo(WB_ERRo),
        .S_ADRo(S_ADRo), .S_DATo(S_DATo), .S_WEo(S_WEo), .S_CYCo(S_CYCo),
        .S_STBo(S_STBo), .S_DATi(S_DATi), .S_ACKi(S_ACKi),
        .ERR_ADDR(ERR_ADDR), .ERR_IRQ(ERR_IRQ)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc_n  = 0;
    int stb_hi_cnt = 0, ack_cnt = 0, err_cnt = 0, irq_cnt = 0;
    int ack_at = 0, err_at = 0;
    logic [DW-1:0] last_sdat = '0;

    // Model expectations for the current cycle.
    logic [N_SLV-1:0] exp_stb = '0;
    logic             exp_cyc = 1'b0, exp_ack = 1'b0, exp_err = 1'b0, exp_irq = 1'b0;
    logic [DW-1:0]    exp_dat = '0;
    logic [AW-1:0]    exp_erraddr = '0;
    logic             exp_in_acc = 1'b0;
    logic [AW-1:0]    exp_sadr = '0;
    logic [DW-1:0]    exp_sdat = '0;
    logic             exp_swe = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic int decode(input logic [AW-1:0] a);
        for (int i = 0; i < N_SLV; i++)
            if ((a & MAP_MASK[i]) == MAP_BASE[i]) return i;
        return -1;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 5))
            0: return 12'h600 | 12'($urandom_range(0, 3));
            1: return 12'h6F0 | 12'($urandom_range(0, 15));
            2: return 12'h700 | 12'($urandom_range(0, 255));
            3: return 12'h800 | 12'($urandom_range(0, 2047));
            default: return 12'($urandom);
        endcase
    endfunction

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Compare process: every cycle, mid-cycle, against the model.
    always @(negedge clk) begin
        if (S_STBo != '0) begin stb_hi_cnt++; last_sdat = S_DATo; end
        if (WB_ACKo) begin ack_cnt++; ack_at = cyc_n; end
        if (WB_ERRo) begin err_cnt++; err_at = cyc_n; end
        if (ERR_IRQ) irq_cnt++;
        check("S_STBo",   32'(S_STBo),   32'(exp_stb));
        check("S_CYCo",   32'(S_CYCo),   32'(exp_cyc));
        check("WB_ACKo",  32'(WB_ACKo),  32'(exp_ack));
        check("WB_ERRo",  32'(WB_ERRo),  32'(exp_err));
        check("ERR_IRQ",  32'(ERR_IRQ),  32'(exp_irq));
        check("WB_DATo",  32'(WB_DATo),  32'(exp_dat));
        check("ERR_ADDR", 32'(ERR_ADDR), 32'(exp_erraddr));
        if (exp_in_acc) begin
            check("S_ADRo", 32'(S_ADRo), 32'(exp_sadr));
            check("S_DATo", 32'(S_DATo), 32'(exp_sdat));
            check("S_WEo",  32'(S_WEo),  32'(exp_swe));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp_idle();
        exp_stb = '0; exp_cyc = 1'b0; exp_ack = 1'b0; exp_err = 1'b0; exp_irq = 1'b0;
        exp_in_acc = 1'b0;
    endtask

    task automatic drive_noise();
        for (int i = 0; i < N_SLV; i++) S_DATi[i*DW +: DW] = 8'($urandom);
        S_ACKi = N_SLV'($urandom);
    endtask

    task automatic idle_cycle();
        WB_CYCi = 1'($urandom); WB_STBi = 1'b0; WB_ADRi = 12'($urandom);
        drive_noise();
        set_exp_idle();
        next_cycle();
    endtask

    task automatic resp_cycle(input logic [AW-1:0] adr, input logic we, input logic ok,
                              input logic [DW-1:0] rd);
        set_exp_idle();
        if (ok) begin
            exp_ack = 1'b1; exp_dat = rd;
        end else begin
            exp_err = 1'b1; exp_irq = 1'b1; exp_erraddr = adr;
            if (!we) exp_dat = 8'hFF;
        end
        // A request presented during the response must not be taken.
        WB_CYCi = 1'($urandom); WB_STBi = 1'($urandom); WB_ADRi = rand_addr();
        WB_DATi = 8'($urandom); WB_WEi = 1'($urandom);
        drive_noise();
        next_cycle();
    endtask

    task automatic run_txn(input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic we,
                           input int dly, input int abort_at, input int fdat, output int t0);
        int sel, n;
        logic ok, abrt;
        logic [DW-1:0] rd;
        sel = decode(adr);
        t0  = cyc_n;
        rd  = '0;
        WB_CYCi = 1'b1; WB_STBi = 1'b1; WB_ADRi = adr; WB_DATi = dat; WB_WEi = we;
        drive_noise();
        set_exp_idle();
        next_cycle();
        if (sel < 0) begin
            resp_cycle(adr, we, 1'b0, rd);
            return;
        end
        if (AUTO[sel])          begin n = 1;       ok = 1'b1; end
        else if (dly < TIMEOUT) begin n = dly + 1; ok = 1'b1; end
        else                    begin n = TIMEOUT; ok = 1'b0; end
        abrt = (abort_at >= 1) && (abort_at <= n);
        if (abrt) n = abort_at;
        for (int k = 1; k <= n; k++) begin
            set_exp_idle();
            exp_stb = N_SLV'(1 << sel); exp_cyc = 1'b1; exp_in_acc = 1'b1;
            exp_sadr = adr; exp_sdat = dat; exp_swe = we;
            WB_CYCi = !(abrt && k == n); WB_STBi = 1'($urandom);
            WB_ADRi = 12'($urandom); WB_DATi = 8'($urandom); WB_WEi = 1'($urandom);
            drive_noise();
            if (!AUTO[sel]) S_ACKi[sel] = ok && !abrt && (k == n);
            if (fdat >= 0) S_DATi[sel*DW +: DW] = 8'(fdat);
            rd = S_DATi[sel*DW +: DW];
            next_cycle();
        end
        if (abrt) idle_cycle();
        else      resp_cycle(adr, we, ok, rd);
    endtask

    initial begin
        int t0, s0, a0, e0, i0, dly, ab;
        logic [AW-1:0] adr;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_S_ADRo", 32'(S_ADRo), 32'h0);
        check("rst_S_DATo", 32'(S_DATo), 32'h0);
        check("rst_S_WEo",  32'(S_WEo),  32'h0);
        rst = 1'b1;
        idle_cycle();

        // Auto-ack read from slave 0 returns 0x5A on the third cycle.
        s0 = stb_hi_cnt;
        run_txn(12'h601, 8'h00, 1'b0, 0, 0, 8'h5A, t0);
        check("d_auto_dat", 32'(WB_DATo), 32'h5A);
        check("d_auto_lat", 32'(ack_at - t0), 32'd2);
        check("d_auto_stb", 32'(stb_hi_cnt - s0), 32'd1);

        // Write 0x3C to slave 2 with 4 wait states.
        s0 = stb_hi_cnt; a0 = ack_cnt;
        run_txn(12'h705, 8'h3C, 1'b1, 4, 0, -1, t0);
        check("d_wait_stb",  32'(stb_hi_cnt - s0), 32'd5);
        check("d_wait_ack",  32'(ack_cnt - a0),    32'd1);
        check("d_wait_sdat", 32'(last_sdat),       32'h3C);

        // Unmapped read errors on the second cycle.
        i0 = irq_cnt;
        run_txn(12'h500, 8'h00, 1'b0, 0, 0, -1, t0);
        check("d_miss_addr", 32'(ERR_ADDR), 32'h500);
        check("d_miss_dat",  32'(WB_DATo),  32'hFF);
        check("d_miss_irq",  32'(irq_cnt - i0), 32'd1);
        check("d_miss_lat",  32'(err_at - t0),  32'd1);

        // Silent slave (slave 3; slave 4 is shadowed by slave 3 in this map) times out.
        s0 = stb_hi_cnt; e0 = err_cnt;
        run_txn(12'h900, 8'h00, 1'b0, 40, 0, -1, t0);
        check("d_to_stb",  32'(stb_hi_cnt - s0), 32'd15);
        check("d_to_err",  32'(err_cnt - e0),    32'd1);
        check("d_to_addr", 32'(ERR_ADDR),        32'h900);

        // Master drops CYC in the second access cycle.
        s0 = stb_hi_cnt; a0 = ack_cnt; e0 = err_cnt;
        run_txn(12'h7AA, 8'h00, 1'b0, 20, 2, -1, t0);
        check("d_abort_stb", 32'(stb_hi_cnt - s0), 32'd2);
        check("d_abort_rsp", 32'((ack_cnt - a0) + (err_cnt - e0)), 32'd0);

        // Reset in the middle of an access.
        a0 = ack_cnt; e0 = err_cnt;
        WB_CYCi = 1'b1; WB_STBi = 1'b1; WB_ADRi = 12'h710; WB_DATi = 8'h11; WB_WEi = 1'b0;
        drive_noise(); S_ACKi = '0; set_exp_idle();
        next_cycle();
        for (int k = 1; k <= 2; k++) begin
            set_exp_idle();
            exp_stb = 5'b00100; exp_cyc = 1'b1; exp_in_acc = 1'b1;
            exp_sadr = 12'h710; exp_sdat = 8'h11; exp_swe = 1'b0;
            drive_noise(); S_ACKi = '0;
            if (k == 1) next_cycle();
        end
        #2 rst = 1'b0;
        #1;
        check("mr_stb",  32'(S_STBo),   32'h0);
        check("mr_cyc",  32'(S_CYCo),   32'h0);
        check("mr_dat",  32'(WB_DATo),  32'h0);
        check("mr_eadr", 32'(ERR_ADDR), 32'h0);
        exp_dat = '0; exp_erraddr = '0;
        set_exp_idle();
        next_cycle();
        WB_CYCi = 1'b0; WB_STBi = 1'b0;
        rst = 1'b1;
        repeat (4) idle_cycle();
        check("mr_norsp", 32'((ack_cnt - a0) + (err_cnt - e0)), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            adr = rand_addr();
            dly = $urandom_range(0, 20);
            ab  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_txn(adr, 8'($urandom), 1'($urandom), dly, ab, -1, t0);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
